ff_capture_arbiter: RTL and testbench
=====================================

// Module: ff_capture_arbiter
//
// PURPOSE
//   Shares one enable-gated capture register among NREQ requesters.
//   Arbitration is round-robin, with a valid/ready handshake per requester.
//   After each capture the register is locked for HOLD_CYCLES so downstream logic
//   (pad/CCRIO-clocked consumers) sees a stable value. Sits between several data
//   sources and a single registered output path in the same clk domain.
//
// PARAMETERS
//   NREQ         4   number of requesters (>=2)
//   DW           8   data width per requester
//   HOLD_CYCLES  3   cycles the captured value is locked before next grant (>=1; elaboration error otherwise)
//
// PORTS
//   clk           in   1        single clock, all logic on posedge
//   rst_n         in   1        synchronous reset, active-low
//   req_valid     in   NREQ     requester i has data to capture
//   req_data      in   NREQ*DW  requester i data at [i*DW +: DW]
//   req_ready     out  NREQ     one-hot grant; handshake = req_valid[i] & req_ready[i]
//   data_o        out  DW       shared captured register
//   data_valid_o  out  1        1-cycle pulse when data_o takes a new value
//   owner_o       out  clog2(NREQ)  index of requester whose data is in data_o
//   busy_o        out  1        high while in HOLD (no grants possible)
//
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state=IDLE, hold counter=0, data_o=0, data_valid_o=0,
//     owner_o=0, busy_o=0. RR pointer set so requester 0 has top priority.
//   - req_ready is combinational from state, req_valid and the RR pointer. It is all-zero while rst_n=0.
//   - FSM states IDLE, HOLD:
//     IDLE: if any req_valid, grant g = first valid index at or after (last_owner+1) mod NREQ.
//           req_ready[g]=1 in that cycle only. At that posedge:
//           data_o<=req_data[g], owner_o<=g, data_valid_o<=1, last_owner<=g, cnt<=HOLD_CYCLES-1, ->HOLD.
//           If no req_valid: stay IDLE, req_ready=0, data_valid_o<=0.
//     HOLD: req_ready=0, busy_o=1, data_o/owner_o unchanged, data_valid_o<=0.
//           If cnt==0 ->IDLE, else cnt<=cnt-1.
//   - Latency: data appears on data_o 1 cycle after the handshake cycle.
//     Min spacing between handshakes is HOLD_CYCLES+1 cycles.
//   - busy_o is registered. It is high exactly HOLD_CYCLES cycles, starting the cycle data_valid_o pulses.
//   - Requests arriving during HOLD wait; no request is lost if req_valid is held.
//   - Requester may deassert req_valid before grant: no capture, no error.
//   - Simultaneous requests resolve by RR only; owner pointer wraps NREQ-1 -> 0.
//   - A single continuous requester is re-granted every HOLD_CYCLES+1 cycles (no starvation when alone).
//   - Reset mid-HOLD or mid-handshake: the reset wins, no capture occurs, all reset values apply on the next cycle.
//   - req_data of non-granted requesters is ignored. X on them must not propagate to data_o.
//
// TESTING
//   1 Reset: rst_n=0 for 2 cycles with all req_valid=1
//     -> req_ready=0, data_o=0, owner_o=0, busy_o=0, data_valid_o=0.
//   2 Single req: req_valid[2]=1, data 0xA5
//     -> req_ready=4'b0100 same cycle; next cycle data_o=0xA5, owner_o=2, data_valid_o=1 for 1 cycle, busy_o=1 for 3 cycles.
//   3 All four valid continuously, data=0x10+i
//     -> grants 0,1,2,3,0 every 4 cycles; data_o sequence 0x10,0x11,0x12,0x13,0x10.
//   4 req_valid[1] raised during HOLD
//     -> req_ready[1] stays 0 until the cycle after cnt reaches 0; then granted, data captured.
//   5 rst_n=0 during 2nd HOLD cycle
//     -> next cycle IDLE, busy_o=0, data_o=0. A pending req_valid[3] is then granted after priority 0..2 checks.
//   6 req_valid[0] pulsed 1 cycle while in HOLD, then dropped
//     -> no grant, data_o unchanged, no data_valid_o pulse.

Source files
------------

// File: rtl/ff_capture_arbiter.sv
// ff_capture_arbiter
//   Shares one capture register among NREQ requesters. A round-robin arbiter
//   grants one valid requester per capture; after each capture the register is
//   locked for HOLD_CYCLES cycles so downstream consumers see a stable value.
//
// Ports
//   clk           clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   req_valid     per-requester valid
//   req_data      per-requester data, requester i at [i*DW +: DW]
//   req_ready     one-hot grant (combinational), zero while in reset or HOLD
//   data_o        captured data
//   data_valid_o  one-cycle pulse when data_o takes a new value
//   owner_o       index of the requester whose data is in data_o
//   busy_o        high while the captured value is locked

module ff_capture_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [DW-1:0]           data_o,
  output logic                    data_valid_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    busy_o
);

  localparam int OW = $clog2(NREQ);
  // Sized for HOLD_CYCLES-1 but at least one bit wide
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("ff_capture_arbiter: HOLD_CYCLES must be >= 1");
  end
  if (NREQ < 2) begin : g_bad_nreq
    $error("ff_capture_arbiter: NREQ must be >= 2");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   last_q, last_d;
  logic [DW-1:0]   data_q, data_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            dv_q, dv_d;
  logic            busy_q, busy_d;

  logic            gnt_found_s;
  logic [OW-1:0]   gnt_idx_s;
  logic [NREQ-1:0] rdy_s;

  // Round-robin search: first valid index at or after last owner + 1
  always_comb begin
    int sum;
    int idx;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(last_q) + k;
      // Wrap without a modulo operator; sum never exceeds 2*NREQ-1
      idx = (sum >= NREQ) ? (sum - NREQ) : sum;
      if (!gnt_found_s && req_valid[idx]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = idx[OW-1:0];
      end
    end
  end

  // Next-state and grant logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    owner_d = owner_q;
    dv_d    = 1'b0;
    busy_d  = 1'b0;
    rdy_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found_s) begin
          rdy_s[gnt_idx_s] = 1'b1;
          // Only the granted slice is read, so other requesters' data never reaches data_o
          data_d  = req_data[int'(gnt_idx_s)*DW +: DW];
          owner_d = gnt_idx_s;
          last_d  = gnt_idx_s;
          dv_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset suppresses any grant in the same cycle, so no handshake can complete
  assign req_ready = rst_n ? rdy_s : '0;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= OW'(NREQ - 1);  // requester 0 gets top priority after reset
      data_q  <= '0;
      owner_q <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign owner_o      = owner_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_ff_capture_arbiter.sv
// Self-checking bench for ff_capture_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.

module tb_ff_capture_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int HOLD = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DW-1:0]     req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic [DW-1:0]          data_o;
  logic                   data_valid_o;
  logic [1:0]             owner_o;
  logic                   busy_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model: remaining locked cycles plus last captured values
  int          m_hold  = 0;
  int          m_last  = NREQ - 1;
  logic [DW-1:0] m_data = '0;
  int          m_owner = 0;
  logic        m_dv    = 1'b0;
  logic        m_busy  = 1'b0;

  int owners[$];
  int datas[$];

  ff_capture_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .owner_o      (owner_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grant, advance model, check outputs
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d, input logic rn);
    logic [NREQ-1:0] exp_rdy;
    int g;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rst_n     = rn;
    #1;
    g = -1;
    if (rn && m_hold == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rn) begin
      m_data = '0; m_owner = 0; m_dv = 1'b0; m_busy = 1'b0; m_hold = 0; m_last = NREQ - 1;
    end else if (g >= 0) begin
      m_data = d[g*DW +: DW]; m_owner = g; m_dv = 1'b1; m_busy = 1'b1; m_hold = HOLD; m_last = g;
    end else begin
      m_dv = 1'b0;
      if (m_hold > 0) m_hold--;
      m_busy = (m_hold > 0);
    end
    #1;
    chk("data_o", 32'(data_o), 32'(m_data));
    chk("owner_o", 32'(owner_o), 32'(m_owner));
    chk("data_valid_o", 32'(data_valid_o), 32'(m_dv));
    chk("busy_o", 32'(busy_o), 32'(m_busy));
  endtask

  initial begin
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    v;
    logic               rn;

    // 1: reset with all requesters valid
    step(4'hF, 32'h13121110, 1'b0);
    step(4'hF, 32'h13121110, 1'b0);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);

    // 2: single requester 2
    step(4'b0100, 32'h00A50000, 1'b1);
    chk("single_data", 32'(data_o), 32'hA5);
    chk("single_owner", 32'(owner_o), 32'h2);
    for (int i = 0; i < 4; i++) step(4'b0000, 32'h0, 1'b1);

    // 3: all four continuously valid, from a fresh reset
    step(4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'hF, 32'h13121110, 1'b1);
      if (data_valid_o) begin
        owners.push_back(int'(owner_o));
        datas.push_back(int'(data_o));
      end
    end
    chk("rr_count", 32'(owners.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_owner", 32'(owners[i]), 32'(i % NREQ));
      chk("rr_data", 32'(datas[i]), 32'(8'h10 + (i % NREQ)));
    end

    // 4: requester 1 raised during HOLD waits for the lock to expire
    step(4'h0, 32'h0, 1'b0);
    step(4'b0001, 32'h000000C3, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0010, 32'h00003C00, 1'b1);
    chk("late_req_data", 32'(data_o), 32'h3C);
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b1);

    // 5: reset during the second HOLD cycle, then pending requester 3
    step(4'b0001, 32'h00000077, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    step(4'b1000, 32'h99000000, 1'b0);
    chk("midhold_rst_data", 32'(data_o), 32'h0);
    step(4'b1000, 32'h99000000, 1'b1);
    chk("after_rst_owner", 32'(owner_o), 32'h3);
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b1);

    // 6: requester 0 pulses for one cycle during HOLD and then drops
    step(4'b0100, 32'h005A0000, 1'b1);
    step(4'b0001, 32'h000000EE, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0000, 32'h0, 1'b1);
    chk("pulse_keep_data", 32'(data_o), 32'h5A);
    chk("pulse_no_dv", 32'(data_valid_o), 32'h0);

    // Random traffic; data of non-valid requesters is X
    for (int n = 0; n < 400; n++) begin
      v  = NREQ'($urandom);
      rn = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (v[i]) d[i*DW +: DW] = DW'($urandom);
        else      d[i*DW +: DW] = 'x;
      end
      step(v, d, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
